// File: rtl/bsk_prm_bus_master_if.sv
// PRM board bus: 16-bit data, 2-bit address, 4-bit chip select and
// active-low read/write strobes.
//   master modport : drives address/CS/data/strobes, receives iD
//   slave modport  : board-side view, drives iD
`timescale 1ns/1ps
interface bsk_prm_bus_master_if;
    logic [15:0] iD;    // read data from board
    logic [15:0] oD;    // write data to board
    logic        oDOe;  // 1 = master drives oD
    logic [1:0]  oA;    // register address
    logic [3:0]  oCS;   // chip select
    logic        oWr;   // write strobe, active-low
    logic        oRd;   // read strobe, active-low

    modport master (
        input  iD,
        output oD, oDOe, oA, oCS, oWr, oRd
    );

    modport slave (
        output iD,
        input  oD, oDOe, oA, oCS, oWr, oRd
    );
endinterface

// File: rtl/bsk_prm_bus_master.sv
// Sequences one PRM command board update: four writes (command low/high in
// check-nibble format, indication, control) then two readbacks (command,
// ID/status) with verification. Owns all strobe timing.
// Ports:
//   iClk, iRes       clock, asynchronous active-high reset
//   iStart           start request (sampled in idle only)
//   iCom, iComInd    command / indication vectors, latched at start
//   iEnable          1 = write ENABLE_CODE to the control register
//   bus              board bus (master modport)
//   oBusy, oDone     sequence in progress / one-cycle completion pulse
//   oErrCom/Pwd/En   readback mismatch flags, held until next start
//   oVersion         firmware version from the status register
`timescale 1ns/1ps
module bsk_prm_bus_master #(
    parameter logic [3:0]  CS          = 4'b0111,
    parameter logic [3:0]  CS_IDLE     = 4'b1111,
    parameter logic [7:0]  PASSWORD    = 8'hA6,
    parameter logic [7:0]  ENABLE_CODE = 8'hE1,
    parameter int unsigned SETUP       = 1,
    parameter int unsigned STROBE      = 4
) (
    input  logic                         iClk,
    input  logic                         iRes,
    input  logic                         iStart,
    input  logic [15:0]                  iCom,
    input  logic [15:0]                  iComInd,
    input  logic                         iEnable,
    bsk_prm_bus_master_if.master         bus,
    output logic                         oBusy,
    output logic                         oDone,
    output logic                         oErrCom,
    output logic                         oErrPwd,
    output logic                         oErrEn,
    output logic [5:0]                   oVersion
);

    typedef enum logic [2:0] {StIdle, StW0, StW1, StW2, StW3, StR1, StR3, StDone} st_e;
    typedef enum logic [1:0] {PhSetup, PhStrobe, PhHold} ph_e;

    // Counters count down to zero, so load length-1.
    localparam logic [3:0] SetupLoad  = 4'(SETUP - 1);
    localparam logic [3:0] StrobeLoad = 4'(STROBE - 1);

    st_e         state_q;
    ph_e         phase_q;
    logic [3:0]  cnt_q;
    logic [15:0] com_q, ind_q;
    logic        en_q;
    logic        wr_q, rd_q, doe_q, busy_q, done_q;
    logic [15:0] d_q;
    logic [1:0]  a_q;
    logic [3:0]  cs_q;
    logic        err_com_q, err_pwd_q, err_en_q;
    logic [5:0]  version_q;

    function automatic logic [15:0] wr_word(st_e st, logic [15:0] c, logic [15:0] ind,
                                            logic en);
        case (st)
            StW0:    wr_word = {c[7:4], ~c[7:4], c[3:0], ~c[3:0]};
            StW1:    wr_word = {c[15:12], ~c[15:12], c[11:8], ~c[11:8]};
            StW2:    wr_word = ind;
            StW3:    wr_word = {8'h00, en ? ENABLE_CODE : 8'h00};
            default: wr_word = 16'h0000;
        endcase
    endfunction

    function automatic logic [1:0] acc_addr(st_e st);
        case (st)
            StW1, StR1: acc_addr = 2'd1;
            StW2:       acc_addr = 2'd2;
            StW3, StR3: acc_addr = 2'd3;
            default:    acc_addr = 2'd0;
        endcase
    endfunction

    function automatic logic is_write(st_e st);
        is_write = (st == StW0) || (st == StW1) || (st == StW2) || (st == StW3);
    endfunction

    function automatic st_e next_st(st_e st);
        case (st)
            StW0:    next_st = StW1;
            StW1:    next_st = StW2;
            StW2:    next_st = StW3;
            StW3:    next_st = StR1;
            StR1:    next_st = StR3;
            StR3:    next_st = StDone;
            default: next_st = StIdle;
        endcase
    endfunction

    always_ff @(posedge iClk or posedge iRes) begin
        if (iRes) begin
            state_q   <= StIdle;
            phase_q   <= PhSetup;
            cnt_q     <= 4'd0;
            com_q     <= 16'h0000;
            ind_q     <= 16'h0000;
            en_q      <= 1'b0;
            wr_q      <= 1'b1;
            rd_q      <= 1'b1;
            doe_q     <= 1'b0;
            d_q       <= 16'h0000;
            a_q       <= 2'd0;
            cs_q      <= CS_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_com_q <= 1'b0;
            err_pwd_q <= 1'b0;
            err_en_q  <= 1'b0;
            version_q <= 6'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (iStart) begin
                        com_q     <= iCom;
                        ind_q     <= iComInd;
                        en_q      <= iEnable;
                        err_com_q <= 1'b0;
                        err_pwd_q <= 1'b0;
                        err_en_q  <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= StW0;
                        phase_q   <= PhSetup;
                        cnt_q     <= SetupLoad;
                        a_q       <= acc_addr(StW0);
                        cs_q      <= CS;
                        // Latched copies are not visible yet; format from inputs.
                        d_q       <= wr_word(StW0, iCom, iComInd, iEnable);
                        doe_q     <= 1'b1;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    case (phase_q)
                        PhSetup: begin
                            if (cnt_q == 4'd0) begin
                                phase_q <= PhStrobe;
                                cnt_q   <= StrobeLoad;
                                if (is_write(state_q)) wr_q <= 1'b0;
                                else                   rd_q <= 1'b0;
                            end else begin
                                cnt_q <= cnt_q - 4'd1;
                            end
                        end
                        PhStrobe: begin
                            if (cnt_q == 4'd0) begin
                                phase_q <= PhHold;
                                wr_q    <= 1'b1;
                                rd_q    <= 1'b1;
                                // Last strobe cycle: read data is settled.
                                if (state_q == StR1) begin
                                    err_com_q <= (bus.iD != com_q);
                                end
                                if (state_q == StR3) begin
                                    err_pwd_q <= (bus.iD[15:8] != PASSWORD);
                                    err_en_q  <= (bus.iD[0] != en_q);
                                    version_q <= bus.iD[7:2];
                                end
                            end else begin
                                cnt_q <= cnt_q - 4'd1;
                            end
                        end
                        default: begin
                            state_q <= next_st(state_q);
                            if (next_st(state_q) == StDone) begin
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                                cs_q   <= CS_IDLE;
                                doe_q  <= 1'b0;
                                a_q    <= 2'd0;
                                d_q    <= 16'h0000;
                            end else begin
                                // CS stays asserted straight into the next access.
                                phase_q <= PhSetup;
                                cnt_q   <= SetupLoad;
                                a_q     <= acc_addr(next_st(state_q));
                                d_q     <= wr_word(next_st(state_q), com_q, ind_q, en_q);
                                doe_q   <= is_write(next_st(state_q));
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    assign bus.oWr   = wr_q;
    assign bus.oRd   = rd_q;
    assign bus.oDOe  = doe_q;
    assign bus.oD    = d_q;
    assign bus.oA    = a_q;
    assign bus.oCS   = cs_q;
    assign oBusy     = busy_q;
    assign oDone     = done_q;
    assign oErrCom   = err_com_q;
    assign oErrPwd   = err_pwd_q;
    assign oErrEn    = err_en_q;
    assign oVersion  = version_q;

endmodule

// File: tb/tb_bsk_prm_bus_master.sv
`timescale 1ns/1ps
module tb_bsk_prm_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] com = 16'h0000;
    logic [15:0] com_ind = 16'h0000;
    logic        enable = 1'b0;
    logic        busy, done, err_com, err_pwd, err_en;
    logic [5:0]  version;

    logic [15:0] rd1_val = 16'h0000;
    logic [15:0] rd3_val = 16'h0000;

    int n_vec = 0;
    int n_err = 0;

    bsk_prm_bus_master_if bus ();

    // Board model: return per-address readback while the read strobe is low.
    assign bus.iD = (!bus.oRd) ? ((bus.oA == 2'd1) ? rd1_val : rd3_val) : 16'h0000;

    bsk_prm_bus_master dut (
        .iClk     (clk),
        .iRes     (rst),
        .iStart   (start),
        .iCom     (com),
        .iComInd  (com_ind),
        .iEnable  (enable),
        .bus      (bus),
        .oBusy    (busy),
        .oDone    (done),
        .oErrCom  (err_com),
        .oErrPwd  (err_pwd),
        .oErrEn   (err_en),
        .oVersion (version)
    );

    always #5 clk = ~clk;

    // Bus monitor, sampled on the falling edge.
    logic [1:0]  wr_addr[$];
    logic [15:0] wr_data[$];
    int          wr_len[$];
    int          wr_pre[$];
    logic [1:0]  rd_addr[$];
    int          overlap = 0, unstable = 0, doe_rd = 0;
    int          run_len = 0, pre_len = 0;
    bit          in_wr = 0;

    always @(negedge clk) begin
        if (rst) begin
            in_wr   = 0;
            run_len = 0;
            pre_len = 0;
        end else begin
            if (!bus.oWr && !bus.oRd) overlap++;
            if (!bus.oRd && bus.oDOe) doe_rd++;
            if (!bus.oWr) begin
                if (!in_wr) begin
                    wr_addr.push_back(bus.oA);
                    wr_data.push_back(bus.oD);
                    wr_pre.push_back(pre_len);
                    run_len = 0;
                    in_wr   = 1;
                end else if (bus.oA != wr_addr[$] || bus.oD != wr_data[$] ||
                             !bus.oDOe || bus.oCS != 4'b0111) begin
                    unstable++;
                end
                run_len++;
            end else if (in_wr) begin
                wr_len.push_back(run_len);
                in_wr = 0;
            end
            if (!bus.oRd && (rd_addr.size() == 0 || pre_len != 0)) rd_addr.push_back(bus.oA);
            if (bus.oCS == 4'b0111 && bus.oWr && bus.oRd) pre_len++;
            else                                          pre_len = 0;
        end
    end

    task automatic clear_logs();
        wr_addr.delete(); wr_data.delete(); wr_len.delete(); wr_pre.delete();
        rd_addr.delete();
        overlap = 0; unstable = 0; doe_rd = 0;
    endtask

    // Starts one sequence and watches 80 cycles; optional second start at cycle second_at.
    task automatic run_seq(input int second_at, output int done_cyc, output int busy_cyc,
                           output int done_cnt);
        @(negedge clk);
        #1;
        clear_logs();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_cyc = 0; busy_cyc = 0; done_cnt = 0;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = n;
            end
            if (n == second_at) begin
                start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (bus.oWr !== 1'b1) begin n_err++; $display("FAIL rst_wr: got %b want 1", bus.oWr); end
        n_vec++; if (bus.oRd !== 1'b1) begin n_err++; $display("FAIL rst_rd: got %b want 1", bus.oRd); end
        n_vec++; if (bus.oCS !== 4'hF) begin n_err++; $display("FAIL rst_cs: got %h want f", bus.oCS); end
        n_vec++; if (bus.oDOe !== 1'b0) begin n_err++; $display("FAIL rst_doe: got %b want 0", bus.oDOe); end
        n_vec++; if ({busy, done, err_com, err_pwd, err_en} !== 5'b0)
            begin n_err++; $display("FAIL rst_flags: got %b want 00000", {busy, done, err_com, err_pwd, err_en}); end
        n_vec++; if (version !== 6'h00) begin n_err++; $display("FAIL rst_version: got %h want 00", version); end
        rst = 1'b0;
        #1 clear_logs();
        repeat (50) @(negedge clk);
        n_vec++; if (wr_addr.size() + rd_addr.size() !== 0)
            begin n_err++; $display("FAIL idle_strobes: got %0d want 0", wr_addr.size() + rd_addr.size()); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_write_format();
        logic [15:0] exp_d [4] = '{16'h3C4B, 16'h1E2D, 16'h00FF, 16'h00E1};
        int dc, bc, cnt;
        com = 16'h1234; com_ind = 16'h00FF; enable = 1'b1;
        rd1_val = 16'h1234; rd3_val = 16'hA691;
        run_seq(0, dc, bc, cnt);
        n_vec++; if (wr_addr.size() !== 4) begin n_err++; $display("FAIL wr_count: got %0d want 4", wr_addr.size()); end
        for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
            n_vec++; if (wr_addr[i] !== 2'(i)) begin n_err++; $display("FAIL wr_addr[%0d]: got %0d want %0d", i, wr_addr[i], i); end
            n_vec++; if (wr_data[i] !== exp_d[i]) begin n_err++; $display("FAIL wr_data[%0d]: got %h want %h", i, wr_data[i], exp_d[i]); end
            n_vec++; if (wr_len[i] !== 4) begin n_err++; $display("FAIL wr_len[%0d]: got %0d want 4", i, wr_len[i]); end
            // first access: one setup cycle; later ones: previous hold + setup
            n_vec++; if (wr_pre[i] !== ((i == 0) ? 1 : 2))
                begin n_err++; $display("FAIL wr_pre[%0d]: got %0d want %0d", i, wr_pre[i], (i == 0) ? 1 : 2); end
        end
        n_vec++; if (rd_addr.size() !== 2) begin n_err++; $display("FAIL rd_count: got %0d want 2", rd_addr.size()); end
        n_vec++; if (rd_addr.size() == 2 && (rd_addr[0] !== 2'd1 || rd_addr[1] !== 2'd3))
            begin n_err++; $display("FAIL rd_order: got %0d,%0d want 1,3", rd_addr[0], rd_addr[1]); end
        n_vec++; if (overlap !== 0) begin n_err++; $display("FAIL strobe_overlap: got %0d want 0", overlap); end
        n_vec++; if (unstable !== 0) begin n_err++; $display("FAIL wr_stable: got %0d want 0", unstable); end
        n_vec++; if (doe_rd !== 0) begin n_err++; $display("FAIL rd_doe: got %0d want 0", doe_rd); end
    endtask

    task automatic test_readback_fail();
        int dc, bc, cnt;
        com = 16'h1234; com_ind = 16'h00FF; enable = 1'b1;
        rd1_val = 16'h1235; rd3_val = 16'h5590;
        run_seq(0, dc, bc, cnt);
        n_vec++; if (err_com !== 1'b1) begin n_err++; $display("FAIL fail_errcom: got %b want 1", err_com); end
        n_vec++; if (err_pwd !== 1'b1) begin n_err++; $display("FAIL fail_errpwd: got %b want 1", err_pwd); end
        n_vec++; if (err_en !== 1'b1) begin n_err++; $display("FAIL fail_erren: got %b want 1", err_en); end
        n_vec++; if (version !== 6'h24) begin n_err++; $display("FAIL fail_version: got %h want 24", version); end
    endtask

    task automatic test_readback_pass();
        int dc, bc, cnt;
        com = 16'h1234; com_ind = 16'h00FF; enable = 1'b1;
        rd1_val = 16'h1234; rd3_val = 16'hA691;
        run_seq(0, dc, bc, cnt);
        n_vec++; if (dc !== 37) begin n_err++; $display("FAIL pass_done_cycle: got %0d want 37", dc); end
        n_vec++; if (bc !== 36) begin n_err++; $display("FAIL pass_busy_cycles: got %0d want 36", bc); end
        n_vec++; if ({err_com, err_pwd, err_en} !== 3'b000)
            begin n_err++; $display("FAIL pass_errs: got %b want 000", {err_com, err_pwd, err_en}); end
        n_vec++; if (version !== 6'h24) begin n_err++; $display("FAIL pass_version: got %h want 24", version); end
    endtask

    task automatic test_disable_ignore();
        int dc, bc, cnt;
        com = 16'hBEEF; com_ind = 16'h0F0F; enable = 1'b0;
        rd1_val = 16'hBEEF; rd3_val = 16'hA690;
        run_seq(10, dc, bc, cnt);
        n_vec++; if (wr_data.size() != 4 || wr_data[3] !== 16'h0000)
            begin n_err++; $display("FAIL dis_a3_data: got %h want 0000", (wr_data.size() == 4) ? wr_data[3] : 16'hxxxx); end
        n_vec++; if (wr_data.size() != 4 || wr_data[0] !== 16'hE1F0)
            begin n_err++; $display("FAIL dis_a0_data: got %h want e1f0", (wr_data.size() == 4) ? wr_data[0] : 16'hxxxx); end
        n_vec++; if (cnt !== 1) begin n_err++; $display("FAIL ign_done_count: got %0d want 1", cnt); end
        n_vec++; if (dc !== 37) begin n_err++; $display("FAIL ign_done_cycle: got %0d want 37", dc); end
        n_vec++; if ({err_com, err_pwd, err_en} !== 3'b000)
            begin n_err++; $display("FAIL dis_errs: got %b want 000", {err_com, err_pwd, err_en}); end
    endtask

    task automatic test_reset_mid();
        int dc, bc, cnt;
        bit found = 0;
        com = 16'h1234; com_ind = 16'h00FF; enable = 1'b1;
        rd1_val = 16'h1234; rd3_val = 16'hA691;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.oWr && bus.oA == 2'd1) begin found = 1; break; end
        end
        n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL mid_find_w1: got %b want 1", found); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (bus.oWr !== 1'b1) begin n_err++; $display("FAIL mid_wr: got %b want 1", bus.oWr); end
        n_vec++; if (bus.oDOe !== 1'b0) begin n_err++; $display("FAIL mid_doe: got %b want 0", bus.oDOe); end
        n_vec++; if (bus.oCS !== 4'hF) begin n_err++; $display("FAIL mid_cs: got %h want f", bus.oCS); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_seq(0, dc, bc, cnt);
        n_vec++; if (wr_addr.size() !== 4) begin n_err++; $display("FAIL mid_wr_count: got %0d want 4", wr_addr.size()); end
        n_vec++; if (wr_addr.size() == 0 || wr_data[0] !== 16'h3C4B)
            begin n_err++; $display("FAIL mid_first_data: got %h want 3c4b", (wr_addr.size() != 0) ? wr_data[0] : 16'hxxxx); end
        n_vec++; if (dc !== 37) begin n_err++; $display("FAIL mid_done_cycle: got %0d want 37", dc); end
    endtask

    initial begin
        test_reset();
        test_write_format();
        test_readback_fail();
        test_readback_pass();
        test_disable_ignore();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
